ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB over a shared single-port memory with a req/rdy handshake. It decodes the latched instruction word to steer the immediate generator, ALU operand muxes, register-file write, memory access and PC update. It sits between the instruction register and the datapath mux selects, and replaces per-instruction single-cycle control when instruction and data memory share one port.

---
 rtl/ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control sequencer over a shared single-port memory.
// Optional performance counters are enabled with the CTRL_PERF_EN macro.
module ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_rdy,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        retire,
  output logic        trap
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // Legal opcode table; the index constants name each entry.
  localparam int NOPC     = 9;
  localparam int IX_OPIMM = 0;
  localparam int IX_LOAD  = 1;
  localparam int IX_JALR  = 2;
  localparam int IX_STORE = 3;
  localparam int IX_BR    = 4;
  localparam int IX_LUI   = 5;
  localparam int IX_AUIPC = 6;
  localparam int IX_JAL   = 7;
  localparam int IX_OP    = 8;

  localparam logic [NOPC-1:0][6:0] OPC_LIST = {
    7'b0110011,  // OP
    7'b1101111,  // JAL
    7'b0010111,  // AUIPC
    7'b0110111,  // LUI
    7'b1100011,  // BRANCH
    7'b0100011,  // STORE
    7'b1100111,  // JALR
    7'b0000011,  // LOAD
    7'b0010011   // OP-IMM
  };

  logic [2:0]      state_reg, state_next;
  logic [6:0]      opcode;
  logic [NOPC-1:0] opc_hit;
  logic            opc_legal;
  logic [2:0]      imm_dec;
  logic            is_load, is_store, is_br, is_jal, is_jalr, is_auipc, is_op;
  logic            unused_instr;

  assign opcode       = instr[6:0];
  assign unused_instr = ^instr[31:7];

  generate
    for (genvar gi = 0; gi < NOPC; gi++) begin : g_opc
      assign opc_hit[gi] = (opcode == OPC_LIST[gi]);
    end
  endgenerate

  assign opc_legal = |opc_hit;
  assign is_load   = opc_hit[IX_LOAD];
  assign is_store  = opc_hit[IX_STORE];
  assign is_br     = opc_hit[IX_BR];
  assign is_jal    = opc_hit[IX_JAL];
  assign is_jalr   = opc_hit[IX_JALR];
  assign is_auipc  = opc_hit[IX_AUIPC];
  assign is_op     = opc_hit[IX_OP];

  always_comb begin
    imm_dec = IMM_NONE;
    if (opc_hit[IX_OPIMM] || is_load || is_jalr) imm_dec = IMM_I;
    else if (is_store)                           imm_dec = IMM_S;
    else if (is_br)                              imm_dec = IMM_B;
    else if (opc_hit[IX_LUI] || is_auipc)        imm_dec = IMM_U;
    else if (is_jal)                             imm_dec = IMM_J;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_RST;
    else        state_reg <= state_next;
  end

  // Outputs are purely combinational so the async reset clears them at once.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    imm_sel    = IMM_NONE;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    retire     = 1'b0;
    trap       = 1'b0;
    case (state_reg)
      S_RST: state_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_sel    = imm_dec;
        state_next = opc_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        imm_sel   = imm_dec;
        alu_b_sel = !(is_op || is_br);
        alu_a_sel = is_auipc;
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_br) begin
          pc_we      = 1'b1;
          pc_sel     = br_taken ? PC_IMM : PC_PLUS4;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_rdy) begin
          if (is_store) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        wb_sel     = is_load ? WB_MEM : ((is_jal || is_jalr) ? WB_PC4 : WB_ALU);
        pc_sel     = is_jal ? PC_IMM : (is_jalr ? PC_ALU : PC_PLUS4);
        state_next = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_next = S_RST;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt_reg, instret_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg   <= 32'd0;
      instret_cnt_reg <= 32'd0;
    end else begin
      if (state_reg != S_RST && state_reg != S_TRAP)
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (retire)
        instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: per-cycle checks of every control output.
module tb_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        mem_rdy = 1'b1;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, alu_a_sel, alu_b_sel;
  logic        reg_we, pc_we, retire, trap;
  logic [2:0]  imm_sel;
  logic [1:0]  wb_sel, pc_sel;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_rdy(mem_rdy), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .retire(retire), .trap(trap)
`ifdef CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {mem_req, mem_we, addr_sel, ir_we, imm_sel, alu_a_sel, alu_b_sel,
                reg_we, wb_sel, pc_we, pc_sel, retire, trap};

  // Field order: req, we, addr_sel, ir_we, imm, a, b, reg_we, wb, pc_we, pc_sel, retire, trap
  function automatic logic [16:0] ov(input logic rq, input logic we, input logic as,
                                     input logic ir, input logic [2:0] im, input logic a,
                                     input logic b, input logic rw, input logic [1:0] wb,
                                     input logic pw, input logic [1:0] ps, input logic rt,
                                     input logic tp);
    return {rq, we, as, ir, im, a, b, rw, wb, pw, ps, rt, tp};
  endfunction

  task automatic chk(input logic [16:0] expv, input string tag);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic rdy, input logic brt, input logic [16:0] expv, input string tag);
    mem_rdy  = rdy;
    br_taken = brt;
    #2;
    chk(expv, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic wb_instr(input logic [31:0] w, input logic [2:0] im, input logic a,
                          input logic b, input logic [1:0] wb, input logic [1:0] ps,
                          input string nm);
    instr = w;
    cyc(1'b1, 1'b0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), {nm, "_fetch"});
    cyc(1'b0, 1'b1, ov(0,0,0,0,im,0,0,0,0,0,0,0,0), {nm, "_decode"});
    cyc(1'b0, 1'b0, ov(0,0,0,0,im,a,b,0,0,0,0,0,0), {nm, "_exec"});
    cyc(1'b0, 1'b1, ov(0,0,0,0,0,0,0,1,wb,1,ps,1,0), {nm, "_wb"});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk(17'd0, "reset_async_clear");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 17'd0, "rst_cycle");
  endtask

  initial begin
    // Reset held low, mem_rdy high: everything quiet.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(17'd0, "in_reset");
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 17'd0, "rst_cycle1");

    // ADDI x1,x0,5
    wb_instr(32'h00500093, 3'd1, 1'b0, 1'b1, 2'd0, 2'd0, "addi");

    // LW with two wait cycles in MEM
    instr = 32'h0000A103;
    cyc(1'b1, 1'b0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), "lw_fetch");
    cyc(1'b1, 1'b0, ov(0,0,0,0,1,0,0,0,0,0,0,0,0), "lw_decode");
    cyc(1'b1, 1'b0, ov(0,0,0,0,1,0,1,0,0,0,0,0,0), "lw_exec");
    cyc(1'b0, 1'b0, ov(1,0,1,0,0,0,0,0,0,0,0,0,0), "lw_mem_wait1");
    cyc(1'b0, 1'b1, ov(1,0,1,0,0,0,0,0,0,0,0,0,0), "lw_mem_wait2");
    cyc(1'b1, 1'b0, ov(1,0,1,0,0,0,0,0,0,0,0,0,0), "lw_mem_rdy");
    cyc(1'b1, 1'b0, ov(0,0,0,0,0,0,0,1,1,1,0,1,0), "lw_wb");

    // BEQ taken then not taken
    instr = 32'h00000463;
    cyc(1'b1, 1'b0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), "beq1_fetch");
    cyc(1'b1, 1'b0, ov(0,0,0,0,3,0,0,0,0,0,0,0,0), "beq1_decode");
    cyc(1'b1, 1'b1, ov(0,0,0,0,3,0,0,0,0,1,1,1,0), "beq1_exec_taken");
    cyc(1'b1, 1'b1, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), "beq2_fetch");
    cyc(1'b1, 1'b1, ov(0,0,0,0,3,0,0,0,0,0,0,0,0), "beq2_decode");
    cyc(1'b1, 1'b0, ov(0,0,0,0,3,0,0,0,0,1,0,1,0), "beq2_exec_not_taken");

    // SW with one fetch wait cycle
    instr = 32'h0020A223;
    cyc(1'b0, 1'b0, ov(1,0,0,0,0,0,0,0,0,0,0,0,0), "sw_fetch_wait");
    cyc(1'b1, 1'b0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), "sw_fetch_rdy");
    cyc(1'b1, 1'b0, ov(0,0,0,0,2,0,0,0,0,0,0,0,0), "sw_decode");
    cyc(1'b1, 1'b0, ov(0,0,0,0,2,0,1,0,0,0,0,0,0), "sw_exec");
    cyc(1'b1, 1'b0, ov(1,1,1,0,0,0,0,0,0,1,0,1,0), "sw_mem");

    // Jumps, AUIPC and R-type
    wb_instr(32'h008000EF, 3'd5, 1'b0, 1'b1, 2'd2, 2'd1, "jal");
    wb_instr(32'h000080E7, 3'd1, 1'b0, 1'b1, 2'd2, 2'd2, "jalr");
    wb_instr(32'h00001117, 3'd4, 1'b1, 1'b1, 2'd0, 2'd0, "auipc");
    wb_instr(32'h002081B3, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, "add");

    // Reset asserted mid-MEM with mem_req high
    instr = 32'h0000A103;
    cyc(1'b1, 1'b0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), "lwr_fetch");
    cyc(1'b1, 1'b0, ov(0,0,0,0,1,0,0,0,0,0,0,0,0), "lwr_decode");
    cyc(1'b1, 1'b0, ov(0,0,0,0,1,0,1,0,0,0,0,0,0), "lwr_exec");
    mem_rdy = 1'b0;
    #2;
    chk(ov(1,0,1,0,0,0,0,0,0,0,0,0,0), "lwr_mem_wait");
    do_reset();
    cyc(1'b1, 1'b0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), "after_rst_fetch");

    // Illegal opcode: trap is sticky until reset
    instr = 32'h0000007F;
    cyc(1'b1, 1'b0, ov(0,0,0,0,0,0,0,0,0,0,0,0,0), "ill_decode");
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b1, ov(0,0,0,0,0,0,0,0,0,0,0,0,1), $sformatf("trap_hold%0d", i));
    do_reset();
    cyc(1'b1, 1'b0, ov(1,0,0,1,0,0,0,0,0,0,0,0,0), "trap_cleared_fetch");

    // Three back-to-back ADDIs from a fresh reset
    do_reset();
`ifdef CTRL_PERF_EN
    vectors++;
    assert (cycle_cnt === 32'd0 && instret_cnt === 32'd0) else begin
      miscompares++;
      $error("FAIL perf_reset observed=%0d/%0d expected=0/0", cycle_cnt, instret_cnt);
    end
`endif
    for (int i = 0; i < 3; i++)
      wb_instr(32'h00500093, 3'd1, 1'b0, 1'b1, 2'd0, 2'd0, $sformatf("addi_b2b%0d", i));
`ifdef CTRL_PERF_EN
    vectors++;
    assert (instret_cnt === 32'd3) else begin
      miscompares++;
      $error("FAIL instret_cnt observed=%0d expected=3", instret_cnt);
    end
    vectors++;
    assert (cycle_cnt === 32'd12) else begin
      miscompares++;
      $error("FAIL cycle_cnt observed=%0d expected=12", cycle_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
